// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: reset defaults, field widths and the opcodes
// used by the fetch stage and the main control decoder.
package mips_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned JIDX_W   = 26;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;

    // Pseudo-direct j target: upper nibble of the delay-slot PC plus word index.
    function automatic logic [31:0] calcJumpTarget(input logic [31:0] pcPlus4,
                                                   input logic [31:0] instr);
        return {pcPlus4[31:28], instr[JIDX_W-1:0], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold it, or clear it to
// a NOP bubble. clear takes priority over load.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instrIn,
    input  logic [31:0] pcPlus4In,
    output logic [31:0] idInstr,
    output logic [31:0] idPcPlus4,
    output logic        idValid
);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            idInstr   <= NOP_INSTR;
            idPcPlus4 <= '0;
            idValid   <= 1'b0;
        end else if (clear) begin
            idInstr   <= NOP_INSTR;
            idPcPlus4 <= '0;
            idValid   <= 1'b0;
        end else if (load) begin
            idInstr   <= instrIn;
            idPcPlus4 <= pcPlus4In;
            idValid   <= 1'b1;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage with PC, next-PC select and IF/ID register.
// Optional fetch/bubble counters are enabled by defining FETCH_PERF_CNT_EN.
module if_id_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                stall,
    input  logic                flush,
    input  logic                branchTaken,
    input  logic [31:0]         branchTarget,
    input  logic                jump,
    output logic [31:0]         imemAddr,
    input  logic [31:0]         imemData,
    output logic [31:0]         pc,
    output logic [31:0]         idInstr,
    output logic [31:0]         idPcPlus4,
    output logic                idValid,
    output logic [OPCODE_W-1:0] opCode
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetchCount,
    output logic [31:0]         bubbleCount
`endif
);

    logic [31:0] pcPlus4;
    logic [31:0] jumpTarget;
    logic        takeJump;
    logic        idClear;
    logic        idLoad;

    assign pcPlus4    = pc + 32'd4;
    assign jumpTarget = calcJumpTarget(idPcPlus4, idInstr);
    // A bubble never redirects, and a stalled jump waits in ID until released.
    assign takeJump   = jump && idValid && !stall;
    assign idClear    = branchTaken || takeJump || flush;
    assign idLoad     = !idClear && !stall;

    assign imemAddr = pc;
    assign opCode   = idInstr[31:26];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pc <= RESET_PC;
        end else if (branchTaken) begin
            pc <= branchTarget & ~32'h3;
        end else if (takeJump) begin
            pc <= jumpTarget;
        end else if (!stall) begin
            pc <= pcPlus4;
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_ifIdReg (
        .clk      (clk),
        .rstN     (rstN),
        .load     (idLoad),
        .clear    (idClear),
        .instrIn  (imemData),
        .pcPlus4In(pcPlus4),
        .idInstr  (idInstr),
        .idPcPlus4(idPcPlus4),
        .idValid  (idValid)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fetchCount  <= '0;
            bubbleCount <= '0;
        end else begin
            if (idLoad)  fetchCount  <= fetchCount + 32'd1;
            if (idClear) bubbleCount <= bubbleCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: a behavioural next-state model pushes the
// expected IF/ID contents per cycle, compared after each rising edge.
module tb_if_id_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rstN;
    logic        stall, flush, branchTaken, jump;
    logic [31:0] branchTarget;
    logic [31:0] imemAddr, imemData, pc, idInstr, idPcPlus4;
    logic        idValid;
    logic [5:0]  opCode;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetchCount, bubbleCount;
`endif

    always #5 clk = ~clk;

    if_id_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .stall       (stall),
        .flush       (flush),
        .branchTaken (branchTaken),
        .branchTarget(branchTarget),
        .jump        (jump),
        .imemAddr    (imemAddr),
        .imemData    (imemData),
        .pc          (pc),
        .idInstr     (idInstr),
        .idPcPlus4   (idPcPlus4),
        .idValid     (idValid),
        .opCode      (opCode)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetchCount  (fetchCount),
        .bubbleCount (bubbleCount)
`endif
    );

    function automatic logic [31:0] imemWord(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_0005;
            32'h0000_0004: return 32'h2009_0007;
            32'h0000_000C: return 32'h012A_4020;
            32'h0000_0010: return 32'h0800_0010;
            default:       return {16'h2400, a[15:0]};
        endcase
    endfunction

    assign imemData = imemWord(imemAddr);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p4;
        logic        valid;
        logic [31:0] fetches;
        logic [31:0] bubbles;
    } expT;

    expT         sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mPc, mInstr, mP4, mFetch, mBubble;
    logic        mValid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mPc = 32'h0; mInstr = 32'h0; mP4 = 32'h0; mValid = 1'b0;
        mFetch = 32'h0; mBubble = 32'h0;
    endtask

    task automatic step(input logic s, input logic f, input logic b,
                        input logic [31:0] bt, input logic j);
        expT e;
        logic bubble;
        stall = s; flush = f; branchTaken = b; branchTarget = bt; jump = j;
        bubble = 1'b1;
        if (b) begin
            mPc = {bt[31:2], 2'b00};
        end else if (j && mValid && !s) begin
            mPc = {mP4[31:28], mInstr[25:0], 2'b00};
        end else if (f) begin
            if (!s) mPc = mPc + 32'd4;
        end else if (s) begin
            bubble = 1'b0;
        end else begin
            bubble = 1'b0;
            mInstr = imemWord(mPc);
            mP4    = mPc + 32'd4;
            mPc    = mPc + 32'd4;
            mValid = 1'b1;
            mFetch = mFetch + 32'd1;
        end
        if (bubble) begin
            mInstr = 32'h0; mP4 = 32'h0; mValid = 1'b0;
            mBubble = mBubble + 32'd1;
        end
        e = '{pc: mPc, instr: mInstr, p4: mP4, valid: mValid, fetches: mFetch, bubbles: mBubble};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sbEmpty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("pc", pc, e.pc);
            check("imemAddr", imemAddr, e.pc);
            check("idValid", {31'b0, idValid}, {31'b0, e.valid});
            check("idInstr", idInstr, e.instr);
            check("opCode", {26'b0, opCode}, {26'b0, e.instr[31:26]});
            if (e.valid) check("idPcPlus4", idPcPlus4, e.p4);
`ifdef FETCH_PERF_CNT_EN
            check("fetchCount", fetchCount, e.fetches);
            check("bubbleCount", bubbleCount, e.bubbles);
`endif
        end
    endtask

    initial begin
        rstN = 1'b0; stall = 1'b0; flush = 1'b0; branchTaken = 1'b0; jump = 1'b0;
        branchTarget = 32'h0;
        modelReset();
        #12;
        check("rstPc", pc, 32'h0);
        check("rstValid", {31'b0, idValid}, 32'h0);
        check("rstInstr", idInstr, 32'h0);
        check("rstPcPlus4", idPcPlus4, 32'h0);
        @(negedge clk);
        rstN = 1'b1;

        step(0, 0, 0, 0, 0);
        check("firstInstr", idInstr, 32'h2008_0005);
        check("firstPcPlus4", idPcPlus4, 32'h4);
        step(0, 0, 0, 0, 0);
        check("secondOpCode", {26'b0, opCode}, 32'h8);
        check("pcAt8", pc, 32'h8);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("stallHeldInstr", idInstr, 32'h2009_0007);
        step(0, 0, 0, 0, 0);
        check("resumePc", pc, 32'hC);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("jInId", idInstr, 32'h0800_0010);
        check("jPcPlus4", idPcPlus4, 32'h14);
        step(1, 0, 0, 0, 1);
        check("jumpStalledPc", pc, 32'h14);
        step(0, 0, 0, 0, 1);
        check("jumpPc", pc, 32'h40);
        // jump asserted over a bubble must not redirect
        step(0, 0, 0, 0, 1);
        check("bubbleJumpPc", pc, 32'h44);
        step(1, 0, 1, 32'h0000_0103, 1);
        check("branchPc", pc, 32'h100);
        check("branchValid", {31'b0, idValid}, 32'h0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        check("flushStallPc", pc, 32'h10C);
        step(0, 0, 1, 32'hFFFF_FFFC, 0);
        step(0, 0, 0, 0, 0);
        check("wrapPc", pc, 32'h0);
        check("wrapPcPlus4", idPcPlus4, 32'h0);
        step(0, 0, 0, 0, 0);

        stall = 1'b1;
        #3;
        rstN = 1'b0;
        #1;
        modelReset();
        check("asyncPc", pc, mPc);
        check("asyncValid", {31'b0, idValid}, {31'b0, mValid});
        check("asyncInstr", idInstr, mInstr);
`ifdef FETCH_PERF_CNT_EN
        check("asyncFetch", fetchCount, 32'h0);
        check("asyncBubble", bubbleCount, 32'h0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the pipelined MIPS core.
- Owns the PC and drives the instruction-memory address.
- Selects the next PC from sequential, branch-redirect or jump sources.
- Presents the latched instruction and its opCode to the ID stage, where the main control decoder consumes it.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset (sll $0,$0,0).

Ports:
- clk  in  1  core clock, all state on rising edge
- rstN  in  1  asynchronous active-low reset
- stall  in  1  from hazard unit; hold PC and IF/ID
- flush  in  1  external kill of IF/ID contents (e.g. exception); PC not affected
- branchTaken  in  1  from EX: branch resolved taken
- branchTarget  in  32  from EX: branch target address
- jump  in  1  from ID control: current ID instruction is j
- imemAddr  out  32  instruction-memory address (= pc)
- imemData  in  32  instruction word, combinational read of imemAddr
- pc  out  32  current fetch PC
- idInstr  out  32  IF/ID instruction
- idPcPlus4  out  32  IF/ID PC+4
- idValid  out  1  IF/ID holds a real instruction
- opCode  out  6  idInstr[31:26], to control decoder

Behaviour:
- Reset (rstN low, asynchronous, any time): pc=RESET_PC, idInstr=NOP_INSTR, idPcPlus4=0, idValid=0. First fetch occurs on the first rising edge after rstN deasserts.
- pcPlus4 = pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- jumpTarget = {idPcPlus4[31:28], idInstr[25:0], 2'b00}.
- branchTarget[1:0] is ignored and forced to 00.
- Next-PC priority, highest first:
  - (1) branchTaken: pc<=branchTarget; IF/ID<=NOP, idValid<=0.
  - (2) jump && idValid && !stall: pc<=jumpTarget; IF/ID<=NOP, idValid<=0.
  - (3) stall: pc, idInstr, idPcPlus4, idValid all held.
  - (4) otherwise: pc<=pcPlus4; idInstr<=imemData, idPcPlus4<=pcPlus4, idValid<=1.
- Simultaneous-event rules:
  - branchTaken overrides stall and jump: the older EX branch wins, and the ID instruction is squashed.
  - jump while stall is ignored. The jump stays in ID and is taken on the first non-stalled cycle.
  - flush (when not overridden by rule 1 or 2): IF/ID<=NOP, idValid<=0, and pc updates per rule 3 or 4. flush with stall: IF/ID is cleared and pc is held.
  - A jump with idValid=0 is ignored, so the NOP bubble never redirects.
- Latency: an instruction fetched at cycle N appears on idInstr/opCode in cycle N+1. Redirect penalty: 1 bubble for jump, 1 bubble in IF/ID for branch (the EX-stage flush of ID/EX is the downstream block's responsibility).
- opCode is combinational from idInstr; it reads 6'b000000 during bubbles, so the decoder sees R-type with idValid=0. Downstream gates regWrite with idValid.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - adds output fetchCount[31:0], incremented on every rule-4 load;
  - adds output bubbleCount[31:0], incremented on every cycle IF/ID is loaded with NOP by rule 1, rule 2 or flush;
  - both counters reset to 0 and wrap at 2^32;
  - stall cycles count in neither.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package mips_pkg:
  - NOP_INSTR, RESET_PC defaults;
  - OPCODE_W=6, JIDX_W=26;
  - opcode constants (OP_RTYPE, OP_J, OP_BEQ, OP_BNE) shared with the control decoder.
- One sub-module, if_id_reg: holds idInstr/idPcPlus4/idValid with load/hold/clear controls.
- Next-PC select and pc register stay in the top.

Test Plan:
- Reset then 3 free-running cycles, imem returns 32'h2008_0005 at 0, 32'h2009_0007 at 4 -> pc goes 0,4,8,C; idInstr=20080005 with idPcPlus4=4 and idValid=1, then 20090007 with idPcPlus4=8; opCode=6'b001000.
- stall high 2 cycles at pc=8 -> pc, idInstr, idValid unchanged for both cycles; resumes at C.
- ID holds j with idInstr=32'h0800_0010, idPcPlus4=32'h0000_0014, no stall -> next pc=32'h0000_0040; idValid=0, idInstr=NOP; with FETCH_PERF_CNT_EN, bubbleCount+1.
- branchTaken=1, branchTarget=32'h0000_0103, stall=1 and jump in ID same cycle -> pc=32'h0000_0100; IF/ID=NOP, idValid=0.
- pc=32'hFFFF_FFFC, no redirect -> pc wraps to 0; idPcPlus4=0.
- rstN pulsed low mid-cycle while stall=1 and idValid=1 -> immediate pc=RESET_PC, idValid=0, idInstr=NOP without waiting for clk.
